// File: rtl/packet_scheduler.sv
// Packet slot scheduler for the HDMI data island: grants ACR, audio samples and InfoFrames by fixed priority.
// Optional SPD InfoFrame support is compiled in with PACKET_SCHEDULER_SPD_EN.
module packet_scheduler #(
  parameter int MAX_PENDING_SAMPLES = 15
) (
  input  logic                                         clk_pixel,
  input  logic                                         reset_n,
  input  logic                                         packet_enable,
  input  logic                                         frame_start,
  input  logic                                         acr_valid,
  input  logic                                         audio_sample_strobe,
  output logic [7:0]                                   packet_type,
  output logic [3:0]                                   sample_present,
  output logic                                         packet_strobe,
  output logic [$clog2(MAX_PENDING_SAMPLES+1)-1:0]     samples_pending,
  output logic                                         overflow
);

  localparam int CNT_W = $clog2(MAX_PENDING_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_FOUR = CNT_W'(4);

  typedef enum logic [2:0] {
    GRANT_NULL = 3'd0,
    GRANT_ACR  = 3'd1,
    GRANT_AUD  = 3'd2,
    GRANT_AVI  = 3'd3,
    GRANT_AIF  = 3'd4,
    GRANT_SPD  = 3'd5
  } grant_e;

  function automatic logic [3:0] present_mask(input logic [2:0] n);
    case (n)
      3'd1:    present_mask = 4'b0001;
      3'd2:    present_mask = 4'b0011;
      3'd3:    present_mask = 4'b0111;
      3'd4:    present_mask = 4'b1111;
      default: present_mask = 4'b0000;
    endcase
  endfunction

  logic             acr_pending_r;
  logic             avi_pending_r;
  logic             aif_pending_r;
`ifdef PACKET_SCHEDULER_SPD_EN
  logic             spd_pending_r;
`endif
  logic [CNT_W-1:0] cnt_r;
  logic             overflow_r;
  logic [7:0]       packet_type_r;
  logic [3:0]       sample_present_r;
  logic             packet_strobe_r;

  grant_e           grant_s;
  logic [2:0]       n_s;
  logic [CNT_W-1:0] post_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             ovf_set_s;
  logic [7:0]       type_s;

  // Priority grant over the pre-edge state, plus the number of samples taken.
  always_comb begin
    grant_s = GRANT_NULL;
    n_s     = 3'd0;
    if (!packet_enable) begin
      grant_s = GRANT_NULL;
    end else if (acr_pending_r) begin
      grant_s = GRANT_ACR;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      grant_s = GRANT_AUD;
    end else if (avi_pending_r) begin
      grant_s = GRANT_AVI;
    end else if (aif_pending_r) begin
      grant_s = GRANT_AIF;
`ifdef PACKET_SCHEDULER_SPD_EN
    end else if (spd_pending_r) begin
      grant_s = GRANT_SPD;
`endif
    end else begin
      grant_s = GRANT_NULL;
    end
    if (grant_s == GRANT_AUD) begin
      n_s = (cnt_r >= CNT_FOUR) ? 3'd4 : cnt_r[2:0];
    end else begin
      n_s = 3'd0;
    end
  end

  // Sample counter update: drain first, then accept the strobe only if room remains.
  always_comb begin
    post_s     = cnt_r - CNT_W'(n_s);
    cnt_next_s = post_s;
    ovf_set_s  = 1'b0;
    if (audio_sample_strobe) begin
      if (post_s == CNT_MAX) begin
        ovf_set_s = 1'b1;
      end else begin
        cnt_next_s = post_s + CNT_W'(1);
      end
    end else begin
      cnt_next_s = post_s;
    end
  end

  // Grant to HB0 packet type mapping.
  always_comb begin
    case (grant_s)
      GRANT_ACR: type_s = 8'h01;
      GRANT_AUD: type_s = 8'h02;
      GRANT_AVI: type_s = 8'h82;
      GRANT_AIF: type_s = 8'h84;
      GRANT_SPD: type_s = 8'h83;
      default:   type_s = 8'h00;
    endcase
  end

  // Request flags, sample counter and registered grant outputs; new requests win over grant clears.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_pending_r    <= 1'b0;
      avi_pending_r    <= 1'b0;
      aif_pending_r    <= 1'b0;
`ifdef PACKET_SCHEDULER_SPD_EN
      spd_pending_r    <= 1'b0;
`endif
      cnt_r            <= {CNT_W{1'b0}};
      overflow_r       <= 1'b0;
      packet_type_r    <= 8'h00;
      sample_present_r <= 4'b0000;
      packet_strobe_r  <= 1'b0;
    end else begin
      acr_pending_r    <= acr_valid   | (acr_pending_r & (grant_s != GRANT_ACR));
      avi_pending_r    <= frame_start | (avi_pending_r & (grant_s != GRANT_AVI));
      aif_pending_r    <= frame_start | (aif_pending_r & (grant_s != GRANT_AIF));
`ifdef PACKET_SCHEDULER_SPD_EN
      spd_pending_r    <= frame_start | (spd_pending_r & (grant_s != GRANT_SPD));
`endif
      cnt_r            <= cnt_next_s;
      overflow_r       <= overflow_r | ovf_set_s;
      packet_strobe_r  <= packet_enable;
      if (packet_enable) begin
        packet_type_r    <= type_s;
        sample_present_r <= present_mask(n_s);
      end else begin
        packet_type_r    <= packet_type_r;
        sample_present_r <= sample_present_r;
      end
    end
  end

  assign packet_type     = packet_type_r;
  assign sample_present  = sample_present_r;
  assign packet_strobe   = packet_strobe_r;
  assign samples_pending = cnt_r;
  assign overflow        = overflow_r;

endmodule

// File: tb/tb_packet_scheduler.sv
// Self-checking bench for packet_scheduler: directed test-plan scenarios plus randomized traffic
// compared against a behavioural model of the scheduling rules.
module tb_packet_scheduler;

  localparam int MAX = 15;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk_pixel = 1'b0;
  logic          reset_n = 1'b0;
  logic          packet_enable = 1'b0;
  logic          frame_start = 1'b0;
  logic          acr_valid = 1'b0;
  logic          audio_sample_strobe = 1'b0;
  logic [7:0]    packet_type;
  logic [3:0]    sample_present;
  logic          packet_strobe;
  logic [CW-1:0] samples_pending;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit m_acr, m_avi, m_aif, m_spd, m_ovf, m_strobe;
  int m_cnt, m_type, m_sp;

  packet_scheduler #(.MAX_PENDING_SAMPLES(MAX)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_enable(packet_enable),
    .frame_start(frame_start), .acr_valid(acr_valid),
    .audio_sample_strobe(audio_sample_strobe), .packet_type(packet_type),
    .sample_present(sample_present), .packet_strobe(packet_strobe),
    .samples_pending(samples_pending), .overflow(overflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acr = 0; m_avi = 0; m_aif = 0; m_spd = 0; m_ovf = 0; m_strobe = 0;
    m_cnt = 0; m_type = 0; m_sp = 0;
  endtask

  task automatic model_edge(input bit en, input bit fs, input bit acr, input bit str);
    int t, n;
    t = 0; n = 0;
    if (en) begin
      if (m_acr) t = 8'h01;
      else if (m_cnt >= 1) begin t = 8'h02; n = (m_cnt < 4) ? m_cnt : 4; end
      else if (m_avi) t = 8'h82;
      else if (m_aif) t = 8'h84;
`ifdef PACKET_SCHEDULER_SPD_EN
      else if (m_spd) t = 8'h83;
`endif
      else t = 8'h00;
    end
    m_cnt = m_cnt - n;
    if (str) begin
      if (m_cnt + 1 > MAX) m_ovf = 1;
      else m_cnt = m_cnt + 1;
    end
    m_acr = acr || (m_acr && !(en && t == 8'h01));
    m_avi = fs  || (m_avi && !(en && t == 8'h82));
    m_aif = fs  || (m_aif && !(en && t == 8'h84));
`ifdef PACKET_SCHEDULER_SPD_EN
    m_spd = fs  || (m_spd && !(en && t == 8'h83));
`endif
    if (en) begin
      m_type = t;
      m_sp   = (1 << n) - 1;
    end
    m_strobe = en;
  endtask

  task automatic compare_all();
    check_value("packet_type", 32'(packet_type), 32'(m_type));
    check_value("sample_present", 32'(sample_present), 32'(m_sp));
    check_value("packet_strobe", 32'(packet_strobe), 32'(m_strobe));
    check_value("samples_pending", 32'(samples_pending), 32'(m_cnt));
    check_value("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Drive one cycle of inputs, advance the model with the same inputs, compare after the edge.
  task automatic step(input bit en, input bit fs, input bit acr, input bit str);
    packet_enable = en; frame_start = fs; acr_valid = acr; audio_sample_strobe = str;
    @(posedge clk_pixel);
    model_edge(en, fs, acr, str);
    #1;
    compare_all();
    packet_enable = 1'b0; frame_start = 1'b0; acr_valid = 1'b0; audio_sample_strobe = 1'b0;
  endtask

  initial begin
    logic [7:0] sweep_exp [4];
`ifdef PACKET_SCHEDULER_SPD_EN
    sweep_exp = '{8'h82, 8'h84, 8'h83, 8'h00};
`else
    sweep_exp = '{8'h82, 8'h84, 8'h00, 8'h00};
`endif
    model_reset();
    repeat (2) @(posedge clk_pixel);
    #1;
    compare_all();
    reset_n = 1'b1;

    // reset then idle
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      check_value("idle_type", 32'(packet_type), 32'h00);
    end
    step(0, 0, 0, 0);

    // InfoFrame sweep
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      check_value("sweep_type", 32'(packet_type), 32'(sweep_exp[i]));
    end

    // priority and residual samples
    repeat (6) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    check_value("prio_acr", 32'(packet_type), 32'h01);
    step(1, 0, 0, 0);
    check_value("prio_aud4", 32'(sample_present), 32'hF);
    check_value("prio_left2", 32'(samples_pending), 32'd2);
    step(1, 0, 0, 0);
    check_value("prio_aud2", 32'(sample_present), 32'h3);
    check_value("prio_left0", 32'(samples_pending), 32'd0);

    // saturation
    repeat (17) step(0, 0, 0, 1);
    check_value("sat_count", 32'(samples_pending), 32'd15);
    check_value("sat_ovf", 32'(overflow), 32'd1);
    step(1, 0, 0, 1);
    check_value("sat_grant_type", 32'(packet_type), 32'h02);
    check_value("sat_grant_sp", 32'(sample_present), 32'hF);
    check_value("sat_grant_count", 32'(samples_pending), 32'd12);
    repeat (4) step(1, 0, 0, 0);

    // collisions
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    check_value("coll_acr1", 32'(packet_type), 32'h01);
    step(1, 0, 0, 0);
    check_value("coll_acr2", 32'(packet_type), 32'h01);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check_value("coll_avi1", 32'(packet_type), 32'h82);
    step(1, 0, 0, 0);
    check_value("coll_avi2", 32'(packet_type), 32'h82);
    repeat (4) step(1, 0, 0, 0);

    // reset mid-operation
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    step(0, 1, 1, 0);
    check_value("pre_reset_count", 32'(samples_pending), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk_pixel);
    #1;
    reset_n = 1'b1;
    step(1, 0, 0, 0);
    check_value("post_reset_type", 32'(packet_type), 32'h00);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
